seq_mac_multiplier: RTL and testbench
=====================================

// Module: seq_mac_multiplier
// PURPOSE
//   Parametrised unsigned sequential shift-add multiplier with optional accumulate (MAC core).
//   - Successor to the fixed-width 2-bit combinational multiplier.
//   - Takes one WIDTH x WIDTH product over WIDTH cycles using a start/done handshake.
//   - Optionally adds the product into a wide accumulator with sticky overflow.
// PARAMETERS
//   WIDTH      8            operand width in bits (>= 2)
//   ACC_WIDTH  2*WIDTH+4    accumulator width in bits (>= 2*WIDTH)
// PORTS
//   clk       in   1          rising-edge clock
//   rst_n     in   1          synchronous active-low reset
//   start     in   1          request a multiply; sampled only when busy=0
//   a         in   WIDTH      multiplicand; sampled with start
//   b         in   WIDTH      multiplier; sampled with start
//   acc_en    in   1          sampled with start; 1 = add the product to acc on completion
//   clr       in   1          synchronous clear of acc and overflow
//   busy      out  1          1 while state != IDLE
//   done      out  1          one-cycle pulse: product is final
//   product   out  2*WIDTH    last completed product
//   acc       out  ACC_WIDTH  accumulator
//   overflow  out  1          sticky: an accumulate carried out of ACC_WIDTH
// BEHAVIOUR
//   - Single clock domain. Reset is synchronous and active-low, named rst_n.
//   - Reset (rst_n=0 at an edge): state=IDLE. busy, done, product, acc and overflow all = 0.
//     Internal counters and registers also clear. Reset aborts any operation in flight.
//   - States:
//     * IDLE -> RUN: on start=1. Latch a, b and acc_en. Clear the partial product. cnt=0.
//     * RUN: one step per edge.
//         - If the multiplier LSB is 1, add the multiplicand (shifted left by cnt) to the partial product.
//         - Shift the multiplier right by 1. cnt++.
//         - After step WIDTH-1: product <= final sum, then go to DONE.
//     * DONE -> IDLE unconditionally after one cycle. done=1 only in DONE.
//   - Latency: start sampled at edge E0; done=1 in the cycle after edge E(WIDTH).
//     The start-to-start throughput is WIDTH+2 cycles.
//   - product holds its value from DONE until the next completion. It is not cleared at start.
//   - Accumulate happens on the edge leaving DONE, if the latched acc_en=1:
//     * acc <= (acc + product) mod 2^ACC_WIDTH.
//     * If there is a carry-out, overflow <= 1.
//     * The new acc is visible in the cycle after done.
//   - clr=1 at any edge: acc <= 0 and overflow <= 0.
//     clr takes priority over a simultaneous accumulate, and that accumulate is discarded.
//   - start while busy=1 (including during DONE) is ignored. Inputs are not re-sampled.
//   - a=0 or b=0 still takes the full WIDTH cycles and yields product=0.
//   - All arithmetic is unsigned. product is exact: max (2^W-1)^2 fits in 2*WIDTH bits.
// TESTING
//   1 Reset: hold rst_n=0 for 2 edges, with start=1 -> busy=0, done=0, product=0, acc=0, overflow=0.
//   2 W=8: a=13, b=11, start for 1 cycle -> done only in cycle E0+9, product=143, busy=0 one cycle later.
//   3 W=8 corners: 255*255 -> 65025. 0*200 -> 0. 1*255 -> 255. Each done exactly 9 cycles after start.
//   4 W=8, ACC_WIDTH=17, acc_en=1: three runs of 255*255 -> acc=65025, 130050, then 64003.
//     overflow=1 after the third run only. Then clr=1 -> acc=0, overflow=0.
//   5 W=8: start(7*9), then pulse start(3*3) with busy=1 -> product=63, exactly one done pulse.
//     clr coinciding with the accumulate edge -> acc=0.
//   6 W=8: rst_n=0 at cycle 4 of RUN -> IDLE next cycle, outputs 0, no done pulse.
//     A new start(6*7) afterwards -> 42.
//   7 W=2: exhaustive a,b in 0..3 (including 3*3=9) -> product == a*b for all 16 pairs.

Source files
------------

// File: rtl/seq_mac_multiplier.sv
// seq_mac_multiplier: unsigned shift-add multiplier, one partial-product step per clock,
// with an optional accumulate of each finished product into a wide sticky-overflow accumulator.
module seq_mac_multiplier #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   acc_en,
  input  logic                   clr,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product,
  output logic [ACC_WIDTH-1:0]   acc,
  output logic                   overflow
);

  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        mcand_q, mcand_d;    // multiplicand, pre-shifted by the step count
  logic [WIDTH-1:0]     mplier_q, mplier_d;  // multiplier, LSB is the current step's bit
  logic [PW-1:0]        pp_q, pp_d;          // running partial product
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 acc_en_q, acc_en_d;
  logic [PW-1:0]        product_q, product_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [PW-1:0]        step_sum;
  logic [ACC_WIDTH:0]   acc_sum;             // extra MSB is the carry-out

  // State and datapath registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      pp_q      <= '0;
      cnt_q     <= '0;
      acc_en_q  <= 1'b0;
      product_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      pp_q      <= pp_d;
      cnt_q     <= cnt_d;
      acc_en_q  <= acc_en_d;
      product_q <= product_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state logic: latch operands, step the shift-add, accumulate on leaving DONE.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    pp_d      = pp_q;
    cnt_d     = cnt_q;
    acc_en_d  = acc_en_q;
    product_d = product_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;

    // The final sum always fits in PW bits, so no carry is lost here.
    step_sum = pp_q + (mplier_q[0] ? mcand_q : '0);
    acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH+1-PW){1'b0}}, product_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_en_d = acc_en;
          pp_d     = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        pp_d     = step_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == LAST_STEP) begin
          product_d = step_sum;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (acc_en_q) begin
          acc_d = acc_sum[ACC_WIDTH-1:0];
          if (acc_sum[ACC_WIDTH]) ovf_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a same-edge accumulate; that accumulate is simply lost.
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign acc      = acc_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Directed bench for seq_mac_multiplier: a WIDTH=8/ACC_WIDTH=17 instance for the main
// vectors and accumulate corners, and a WIDTH=2 instance swept exhaustively.
module tb_seq_mac_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        start8, acc_en8, clr8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, ovf8;
  logic [15:0] prod8;
  logic [16:0] acc8;

  // WIDTH=2 instance
  logic        start2, acc_en2, clr2;
  logic [1:0]  a2, b2;
  logic        busy2, done2, ovf2;
  logic [3:0]  prod2;
  logic [7:0]  acc2;

  seq_mac_multiplier #(.WIDTH(8), .ACC_WIDTH(17)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .acc_en(acc_en8), .clr(clr8),
    .busy(busy8), .done(done8), .product(prod8), .acc(acc8), .overflow(ovf8)
  );

  seq_mac_multiplier #(.WIDTH(2), .ACC_WIDTH(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .acc_en(acc_en2), .clr(clr2),
    .busy(busy2), .done(done2), .product(prod2), .acc(acc2), .overflow(ovf2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one W=8 multiply from IDLE; returns edges from the start edge to done (inclusive)
  // and the product seen right after the start edge. lat=-1 if done never shows up.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ten,
                      output int lat, output logic [15:0] p0);
    a8 = ta; b8 = tb; acc_en8 = ten; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    p0  = prod8;
    lat = 1;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    if (!done8) lat = -1;
  endtask

  task automatic run2(input logic [1:0] ta, input logic [1:0] tb, output int lat);
    a2 = ta; b2 = tb; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 20) begin
      tick();
      lat++;
    end
    if (!done2) lat = -1;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t        tbl[7];
  int          lat;
  logic [15:0] p0;
  logic [15:0] prev_p;
  int          dones, donecyc;
  logic        saw_done;

  initial begin
    tbl[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    tbl[3] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
    tbl[4] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
    tbl[5] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    tbl[6] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};

    // Reset held for two edges with start asserted
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'd5; b8 = 8'd5; acc_en8 = 1'b1; clr8 = 1'b0;
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3; acc_en2 = 1'b0; clr2 = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_product", prod8, 0);
    chk("rst_acc", acc8, 0);
    chk("rst_overflow", ovf8, 0);
    chk("rst_busy_w2", busy2, 0);
    start8 = 1'b0; start2 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", busy8, 0);

    // Table of products, each with fixed latency and product held across start
    prev_p = 16'd0;
    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, 1'b0, lat, p0);
      chk($sformatf("v%0d_held_at_start", i), p0, prev_p);
      chk($sformatf("v%0d_latency", i), lat, 9);
      chk($sformatf("v%0d_product", i), prod8, tbl[i].p);
      tick();
      chk($sformatf("v%0d_done_pulse", i), done8, 0);
      chk($sformatf("v%0d_busy_clear", i), busy8, 0);
      prev_p = tbl[i].p;
    end
    chk("acc_untouched", acc8, 0);

    // Accumulate 255*255 three times into a 17-bit accumulator
    run8(8'd255, 8'd255, 1'b1, lat, p0);
    chk("acc1_not_yet", acc8, 0);
    tick();
    chk("acc1", acc8, 65025);
    chk("acc1_ovf", ovf8, 0);
    run8(8'd255, 8'd255, 1'b1, lat, p0);
    tick();
    chk("acc2", acc8, 130050);
    chk("acc2_ovf", ovf8, 0);
    run8(8'd255, 8'd255, 1'b1, lat, p0);
    tick();
    chk("acc3", acc8, 64003);
    chk("acc3_ovf", ovf8, 1);
    run8(8'd2, 8'd3, 1'b0, lat, p0);
    tick();
    chk("acc_en0_keeps", acc8, 64003);
    chk("ovf_sticky", ovf8, 1);
    clr8 = 1'b1;
    tick();
    clr8 = 1'b0;
    chk("clr_acc", acc8, 0);
    chk("clr_ovf", ovf8, 0);

    // Start pulses while busy (RUN and DONE) are ignored; clr on the accumulate edge wins
    a8 = 8'd7; b8 = 8'd9; acc_en8 = 1'b1; start8 = 1'b1;
    tick();
    dones = 0; donecyc = 0;
    for (int k = 1; k <= 20; k++) begin
      start8 = (k == 3 || k == 9);
      a8 = 8'd3; b8 = 8'd3;
      clr8 = done8;
      tick();
      if (done8) begin
        dones++;
        donecyc = k;
      end
    end
    start8 = 1'b0; clr8 = 1'b0;
    chk("busy_start_dones", dones, 1);
    chk("busy_start_donecyc", donecyc, 8);
    chk("busy_start_product", prod8, 63);
    chk("clr_beats_acc", acc8, 0);
    chk("clr_beats_acc_ovf", ovf8, 0);

    // Make acc nonzero, then reset mid-run
    run8(8'd2, 8'd3, 1'b1, lat, p0);
    tick();
    chk("pre_rst_acc", acc8, 6);
    a8 = 8'd100; b8 = 8'd100; acc_en8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("midrun_busy", busy8, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_product", prod8, 0);
    chk("abort_acc", acc8, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8 || busy8) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    run8(8'd6, 8'd7, 1'b0, lat, p0);
    chk("after_abort_latency", lat, 9);
    chk("after_abort_product", prod8, 42);
    tick();

    // W=2 exhaustive sweep
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run2(2'(x), 2'(y), lat);
        chk($sformatf("w2_%0dx%0d_latency", x, y), lat, 3);
        chk($sformatf("w2_%0dx%0d", x, y), prod2, x * y);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
